// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic {
      MEM_IDLE = 1'b0,
      MEM_WAIT = 1'b1
   } mem_state_t;

   localparam logic [4:0] REG_X0 = 5'd0;
   localparam int DEF_MEM_TIMEOUT = 16;

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard-controller signal bundle; master is the datapath side, slave the controller.
interface hazard_unit_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       rs1D;
   logic [4:0]       rs2D;
   logic [4:0]       rdE;
   logic             ResultSrcE0;
   logic             PCSrcE;
   logic             MemReqM;
   logic             dmem_ready;
   logic             dmem_req;
   logic             StallF;
   logic             StallD;
   logic             StallE;
   logic             StallM;
   logic             FlushD;
   logic             FlushE;
   logic             FlushW;
   logic             mem_fault;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_events;

   modport master (
      output rs1D, rs2D, rdE, ResultSrcE0, PCSrcE, MemReqM, dmem_ready,
      input  dmem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
      input  mem_fault, stall_cycles, flush_events
   );

   modport slave (
      input  rs1D, rs2D, rdE, ResultSrcE0, PCSrcE, MemReqM, dmem_ready,
      output dmem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
      output mem_fault, stall_cycles, flush_events
   );
endinterface

// File: rtl/hazard_unit_mem_wait_fsm.sv
// Data-memory wait tracker: stalls while an access is outstanding, releases and flags a
// sticky fault if the memory fails to answer within MEM_TIMEOUT cycles.
module mem_wait_fsm
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic mem_req,
   input  logic dmem_ready,
   output logic mem_stall,
   output logic dmem_req,
   output logic mem_fault
);
   localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

   mem_state_t    state, state_nxt;
   logic [CW-1:0] wait_cnt, cnt_nxt;
   logic          fault_set;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= MEM_IDLE;
         wait_cnt  <= '0;
         mem_fault <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= cnt_nxt;
         if (fault_set) mem_fault <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = wait_cnt;
      mem_stall = 1'b0;
      dmem_req  = 1'b0;
      fault_set = 1'b0;
      unique case (state)
         MEM_IDLE: begin
            dmem_req = mem_req;
            if (mem_req && !dmem_ready) begin
               mem_stall = 1'b1;
               state_nxt = MEM_WAIT;
               cnt_nxt   = CW'(1);
            end
         end
         MEM_WAIT: begin
            dmem_req = 1'b1;
            if (dmem_ready) begin
               state_nxt = MEM_IDLE;
               cnt_nxt   = '0;
            end else if (wait_cnt == LAST) begin
               // Give up: free the pipeline rather than hang, but remember it happened.
               fault_set = 1'b1;
               state_nxt = MEM_IDLE;
               cnt_nxt   = '0;
            end else begin
               mem_stall = 1'b1;
               cnt_nxt   = wait_cnt + CW'(1);
            end
         end
      endcase
   end

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage RV32 pipeline: load-use, redirects, memory waits,
// plus stall/flush performance counters.
module hazard_unit
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
   parameter int CNT_W       = 32
) (
   input logic          clk,
   input logic          rst_n,
   hazard_unit_if.slave hz
);
   logic             mem_stall;
   logic             lw_stall;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_events;

   mem_wait_fsm #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_mem_wait (
      .clk        (clk),
      .rst_n      (rst_n),
      .mem_req    (hz.MemReqM),
      .dmem_ready (hz.dmem_ready),
      .mem_stall  (mem_stall),
      .dmem_req   (hz.dmem_req),
      .mem_fault  (hz.mem_fault)
   );

   assign lw_stall = hz.ResultSrcE0 && (hz.rdE != REG_X0) &&
                     ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));

   // A memory wait freezes everything up to MEM; load-use and redirects replay after release.
   always_comb begin
      hz.StallF = lw_stall;
      hz.StallD = lw_stall;
      hz.StallE = 1'b0;
      hz.StallM = 1'b0;
      hz.FlushD = hz.PCSrcE;
      hz.FlushE = lw_stall | hz.PCSrcE;
      hz.FlushW = 1'b0;
      if (mem_stall) begin
         hz.StallF = 1'b1;
         hz.StallD = 1'b1;
         hz.StallE = 1'b1;
         hz.StallM = 1'b1;
         hz.FlushD = 1'b0;
         hz.FlushE = 1'b0;
         hz.FlushW = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         stall_cycles <= stall_cycles + CNT_W'(hz.StallF);
         flush_events <= flush_events + CNT_W'(hz.PCSrcE & ~mem_stall);
      end
   end

   assign hz.stall_cycles = stall_cycles;
   assign hz.flush_events = flush_events;

endmodule
